// File: rtl/data_sram_responder.sv
// Data SRAM slave for the MEM stage: byte-enabled writes, registered word reads,
// optional wait states. Define DSRAM_ACCESS_CNT_EN to add rd_cnt/wr_cnt access counters.
module data_sram_responder #(
  parameter int    ADDR_W      = 10,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stall
`ifdef DSRAM_ACCESS_CNT_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [3:0]          req_we;
  logic [ADDR_W-1:0]   req_idx;
  logic [31:0]         req_wdata;

  logic                acc_go;
  logic [3:0]          acc_we;
  logic [ADDR_W-1:0]   acc_idx;
  logic [31:0]         acc_wdata;

  logic [31:0]         mem [DEPTH];
  logic [ADDR_W-1:0]   in_idx;
  logic                unused_addr_bits;

  // Byte offset and bits above the array depth are dropped, so addresses wrap.
  assign in_idx           = data_sram_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_we    <= 4'd0;
      req_idx   <= '0;
      req_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: if (data_sram_en && WAIT_CYCLES != 0) begin
          state     <= WAIT;
          cnt       <= CNT_INIT;
          req_we    <= data_sram_we;
          req_idx   <= in_idx;
          req_wdata <= data_sram_wdata;
        end
        WAIT: begin
          if (cnt == 4'd0) state <= IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The access fires either straight from the inputs (no wait states) or from
  // the latched request on the last wait cycle; never while reset is held.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      acc_go    = resetn && data_sram_en;
      acc_we    = data_sram_we;
      acc_idx   = in_idx;
      acc_wdata = data_sram_wdata;
      stall     = 1'b0;
    end else begin
      acc_go    = resetn && (state == WAIT) && (cnt == 4'd0);
      acc_we    = req_we;
      acc_idx   = req_idx;
      acc_wdata = req_wdata;
      stall     = resetn && (((state == IDLE) && data_sram_en) ||
                             ((state == WAIT) && (cnt != 4'd0)));
    end
  end

  always_ff @(posedge clk) begin
    if (acc_go) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_we[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  // Read-before-write: a write access also returns the old word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     data_sram_rdata <= 32'd0;
    else if (acc_go) data_sram_rdata <= mem[acc_idx];
  end

`ifdef DSRAM_ACCESS_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt <= 32'd0;
      wr_cnt <= 32'd0;
    end else if (acc_go) begin
      if (acc_we == 4'd0) rd_cnt <= rd_cnt + 32'd1;
      else                wr_cnt <= wr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench: instance 0 has no wait states, 1 has three, 2 has four.
module tb_data_sram_responder;

  logic              clk;
  logic [2:0]        rstn;
  logic [2:0]        en;
  logic [2:0][3:0]   we;
  logic [2:0][31:0]  addr;
  logic [2:0][31:0]  wdata;
  logic [2:0][31:0]  rdata;
  logic [2:0]        stall;
`ifdef DSRAM_ACCESS_CNT_EN
  logic [2:0][31:0]  rd_cnt;
  logic [2:0][31:0]  wr_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DSRAM_ACCESS_CNT_EN
  `define CNT_PORTS(k) , .rd_cnt(rd_cnt[k]), .wr_cnt(wr_cnt[k])
`else
  `define CNT_PORTS(k)
`endif

  data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_n0 (
    .clk(clk), .resetn(rstn[0]), .data_sram_en(en[0]), .data_sram_we(we[0]),
    .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]),
    .data_sram_rdata(rdata[0]), .stall(stall[0]) `CNT_PORTS(0));

  data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_n3 (
    .clk(clk), .resetn(rstn[1]), .data_sram_en(en[1]), .data_sram_we(we[1]),
    .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]),
    .data_sram_rdata(rdata[1]), .stall(stall[1]) `CNT_PORTS(1));

  data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(4)) u_n4 (
    .clk(clk), .resetn(rstn[2]), .data_sram_en(en[2]), .data_sram_we(we[2]),
    .data_sram_addr(addr[2]), .data_sram_wdata(wdata[2]),
    .data_sram_rdata(rdata[2]), .stall(stall[2]) `CNT_PORTS(2));

  // Issue one request; sc returns the number of cycles stall was seen high.
  // With junk set, conflicting inputs are driven while the request waits.
  task automatic do_acc(input int i, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d, input bit junk, output int sc);
    @(negedge clk);
    en[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    sc = 0;
    #1;
    while (stall[i] && sc < 40) begin
      sc++;
      @(posedge clk); #1;
      if (junk) begin
        en[i] = 1'b1; we[i] = 4'hF; addr[i] = a; wdata[i] = 32'hFFFF0000;
      end else begin
        en[i] = 1'b0;
      end
      #1;
    end
    @(posedge clk); #1;
    en[i] = 1'b0; we[i] = 4'h0;
  endtask

  task automatic test_reset();
    rstn = 3'b000;
    en = 3'b111; we = '0; addr = '0; wdata = '0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (stall[k] !== 1'b0) begin
        n_fail++; $display("FAIL reset_stall[%0d]: got %b expected 0", k, stall[k]);
      end
      n_checks++;
      if (rdata[k] !== 32'd0) begin
        n_fail++; $display("FAIL reset_rdata[%0d]: got %h expected 00000000", k, rdata[k]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    en = 3'b000;
    rstn = 3'b111;
  endtask

  task automatic test_basic_rw();
    int sc;
    do_acc(0, 4'hF, 32'h1c, 32'hDEADBEEF, 0, sc);
    n_checks++;
    if (sc !== 0) begin n_fail++; $display("FAIL n0_write_stall: got %0d expected 0", sc); end
    do_acc(0, 4'h0, 32'h1c, 32'h0, 0, sc);
    n_checks++;
    if (sc !== 0) begin n_fail++; $display("FAIL n0_read_stall: got %0d expected 0", sc); end
    n_checks++;
    if (rdata[0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL n0_read: got %h expected deadbeef", rdata[0]);
    end
  endtask

  task automatic test_byte_enable();
    int sc;
    do_acc(0, 4'hF, 32'h40, 32'h11223344, 0, sc);
    do_acc(0, 4'b0101, 32'h40, 32'hAABBCCDD, 0, sc);
    n_checks++;
    if (rdata[0] !== 32'h11223344) begin
      n_fail++; $display("FAIL byte_en_old_word: got %h expected 11223344", rdata[0]);
    end
    do_acc(0, 4'h0, 32'h40, 32'h0, 0, sc);
    n_checks++;
    if (rdata[0] !== 32'h11BB33DD) begin
      n_fail++; $display("FAIL byte_en_merge: got %h expected 11bb33dd", rdata[0]);
    end
  endtask

  task automatic test_wrap_and_hold();
    int sc;
    do_acc(0, 4'hF, 32'h00001000, 32'h55AA55AA, 0, sc);
    do_acc(0, 4'h0, 32'h00000000, 32'h0, 0, sc);
    n_checks++;
    if (rdata[0] !== 32'h55AA55AA) begin
      n_fail++; $display("FAIL wrap_read: got %h expected 55aa55aa", rdata[0]);
    end
    // we set with en low must neither write nor disturb rdata
    @(negedge clk);
    en[0] = 1'b0; we[0] = 4'hF; addr[0] = 32'h1c; wdata[0] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (rdata[0] !== 32'h55AA55AA) begin
      n_fail++; $display("FAIL en0_hold: got %h expected 55aa55aa", rdata[0]);
    end
    do_acc(0, 4'h0, 32'h1c, 32'h0, 0, sc);
    n_checks++;
    if (rdata[0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL en0_no_write: got %h expected deadbeef", rdata[0]);
    end
  endtask

  task automatic test_wait_states();
    int sc;
    do_acc(1, 4'hF, 32'h20, 32'h12345678, 0, sc);
    n_checks++;
    if (sc !== 3) begin n_fail++; $display("FAIL n3_write_stall: got %0d expected 3", sc); end
    do_acc(1, 4'h0, 32'h20, 32'h0, 1, sc);
    n_checks++;
    if (sc !== 3) begin n_fail++; $display("FAIL n3_read_stall: got %0d expected 3", sc); end
    n_checks++;
    if (rdata[1] !== 32'h12345678) begin
      n_fail++; $display("FAIL n3_read: got %h expected 12345678", rdata[1]);
    end
    do_acc(1, 4'h0, 32'h20, 32'h0, 0, sc);
    n_checks++;
    if (rdata[1] !== 32'h12345678) begin
      n_fail++; $display("FAIL n3_junk_ignored: got %h expected 12345678", rdata[1]);
    end
  endtask

  task automatic test_reset_mid_wait();
    int sc;
    do_acc(2, 4'hF, 32'h30, 32'hCAFEF00D, 0, sc);
    n_checks++;
    if (sc !== 4) begin n_fail++; $display("FAIL n4_write_stall: got %0d expected 4", sc); end
    do_acc(2, 4'h0, 32'h30, 32'h0, 0, sc);
    n_checks++;
    if (rdata[2] !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL n4_read: got %h expected cafef00d", rdata[2]);
    end
    @(negedge clk);
    en[2] = 1'b1; we[2] = 4'hF; addr[2] = 32'h30; wdata[2] = 32'h0BADBEEF;
    @(posedge clk); #1;
    en[2] = 1'b0; we[2] = 4'h0;
    @(posedge clk); #2;
    n_checks++;
    if (stall[2] !== 1'b1) begin
      n_fail++; $display("FAIL n4_pre_reset_stall: got %b expected 1", stall[2]);
    end
    rstn[2] = 1'b0;
    #1;
    n_checks++;
    if (stall[2] !== 1'b0) begin
      n_fail++; $display("FAIL n4_abort_stall: got %b expected 0", stall[2]);
    end
    n_checks++;
    if (rdata[2] !== 32'd0) begin
      n_fail++; $display("FAIL n4_abort_rdata: got %h expected 00000000", rdata[2]);
    end
    @(negedge clk);
    rstn[2] = 1'b1;
    repeat (6) @(posedge clk);
    do_acc(2, 4'h0, 32'h30, 32'h0, 0, sc);
    n_checks++;
    if (sc !== 4) begin n_fail++; $display("FAIL n4_post_stall: got %0d expected 4", sc); end
    n_checks++;
    if (rdata[2] !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL n4_write_aborted: got %h expected cafef00d", rdata[2]);
    end
`ifdef DSRAM_ACCESS_CNT_EN
    n_checks++;
    if (wr_cnt[2] !== 32'd0) begin
      n_fail++; $display("FAIL n4_wr_cnt: got %0d expected 0", wr_cnt[2]);
    end
    n_checks++;
    if (rd_cnt[2] !== 32'd1) begin
      n_fail++; $display("FAIL n4_rd_cnt: got %0d expected 1", rd_cnt[2]);
    end
`endif
  endtask

`ifdef DSRAM_ACCESS_CNT_EN
  task automatic test_counters();
    int sc;
    @(negedge clk); rstn[0] = 1'b0;
    @(negedge clk); rstn[0] = 1'b1;
    n_checks++;
    if (rd_cnt[0] !== 32'd0 || wr_cnt[0] !== 32'd0) begin
      n_fail++; $display("FAIL cnt_reset: got %0d/%0d expected 0/0", rd_cnt[0], wr_cnt[0]);
    end
    do_acc(0, 4'h0, 32'h100, 32'h0, 0, sc);
    do_acc(0, 4'hF, 32'h104, 32'h1, 0, sc);
    do_acc(0, 4'h0, 32'h104, 32'h0, 0, sc);
    do_acc(0, 4'h0, 32'h100, 32'h0, 0, sc);
    do_acc(0, 4'h3, 32'h108, 32'h2, 0, sc);
    do_acc(0, 4'h0, 32'h108, 32'h0, 0, sc);
    do_acc(0, 4'h8, 32'h10c, 32'h3, 0, sc);
    do_acc(0, 4'h0, 32'h10c, 32'h0, 0, sc);
    n_checks++;
    if (rd_cnt[0] !== 32'd5) begin
      n_fail++; $display("FAIL rd_cnt: got %0d expected 5", rd_cnt[0]);
    end
    n_checks++;
    if (wr_cnt[0] !== 32'd3) begin
      n_fail++; $display("FAIL wr_cnt: got %0d expected 3", wr_cnt[0]);
    end
    @(negedge clk);
    force u_n0.rd_cnt = 32'hFFFFFFFF;
    #1;
    release u_n0.rd_cnt;
    do_acc(0, 4'h0, 32'h100, 32'h0, 0, sc);
    n_checks++;
    if (rd_cnt[0] !== 32'd0) begin
      n_fail++; $display("FAIL rd_cnt_wrap: got %h expected 00000000", rd_cnt[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_rw();
    test_byte_enable();
    test_wrap_and_hold();
    test_wait_states();
    test_reset_mid_wait();
`ifdef DSRAM_ACCESS_CNT_EN
    test_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
